mem_arbiter: RTL and testbench

//   Shares one single-port synchronous 64K x 8 RAM between three requesters: VGA fetch
//   (read-only), the LCR580 CPU, and a boot/DMA loader. Sits between these clients and
//   the RAM macro. Drives the CPU clock-enable, so the CPU advances only when its access completes.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the three-client RAM arbiter: slot FSM states and owner IDs.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_VGA = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LDR = 2'd2
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Fixed-priority winner select (VGA > CPU > loader); a starved loader outranks
// the CPU but never VGA.
import mem_arbiter_pkg::*;

module mem_arbiter_pick (
  input  logic   vga_pend,
  input  logic   cpu_pend,
  input  logic   ldr_pend,
  input  logic   starved,
  output logic   win_valid,
  output owner_t win_owner
);

  // priority/starvation winner select
  always_comb begin
    win_valid = 1'b1;
    win_owner = OWN_VGA;
    if (vga_pend) begin
      win_owner = OWN_VGA;
    end else if (ldr_pend && starved) begin
      win_owner = OWN_LDR;
    end else if (cpu_pend) begin
      win_owner = OWN_CPU;
    end else if (ldr_pend) begin
      win_owner = OWN_LDR;
    end else begin
      win_valid = 1'b0;
      win_owner = OWN_VGA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-cycle-slot arbiter sharing one synchronous 64K x 8 RAM between VGA fetch,
// the CPU (stalled via cpu_ce) and a boot/DMA loader.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int         AW       = 16,
  parameter int         DW       = 8,
  parameter logic [2:0] VGA_BASE = 3'b010,
  parameter int         STARVE   = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ack,
  output logic          cpu_ce,
  input  logic          vga_req,
  input  logic [12:0]   vga_a,
  output logic [DW-1:0] vga_q,
  output logic          vga_ack,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_a,
  input  logic [DW-1:0] ldr_d,
  input  logic          ldr_we,
  output logic [DW-1:0] ldr_q,
  output logic          ldr_ack,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_r, state_nx_s;
  owner_t            owner_r, win_owner_s;
  logic              win_valid_s, ldr_win_s, slot_we_r;
  logic              arb_s, done_s, starved_s;
  logic              vga_pend_s, cpu_pend_s, ldr_pend_s;
  logic [AW-1:0]     ram_a_r, sel_a_s;
  logic [DW-1:0]     ram_d_r, sel_d_s;
  logic              ram_we_r, sel_we_s;
  logic [DW-1:0]     cpu_q_r, vga_q_r, ldr_q_r;
  logic              cpu_ack_r, vga_ack_r, ldr_ack_r;
  logic [CNT_W-1:0]  starve_cnt_r;

  // The slot owner is masked at its own completion edge as well as in its
  // ack cycle, so a request still held at that edge is never served twice.
  assign vga_pend_s = vga_req & ~vga_ack_r & ~(done_s & (owner_r == OWN_VGA));
  assign cpu_pend_s = cpu_req & ~cpu_ack_r & ~(done_s & (owner_r == OWN_CPU));
  assign ldr_pend_s = ldr_req & ~ldr_ack_r & ~(done_s & (owner_r == OWN_LDR));
  assign starved_s  = (starve_cnt_r >= STARVE_TH);
  assign ldr_win_s  = win_valid_s & (win_owner_s == OWN_LDR);

  mem_arbiter_pick u_pick (
    .vga_pend  (vga_pend_s),
    .cpu_pend  (cpu_pend_s),
    .ldr_pend  (ldr_pend_s),
    .starved   (starved_s),
    .win_valid (win_valid_s),
    .win_owner (win_owner_s)
  );

  // slot FSM next state; arbitration happens leaving IDLE or DATA
  always_comb begin
    state_nx_s = state_r;
    arb_s      = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arb_s      = 1'b1;
        state_nx_s = win_valid_s ? ST_ADDR : ST_IDLE;
      end
      ST_ADDR: state_nx_s = ST_DATA;
      ST_DATA: begin
        arb_s      = 1'b1;
        done_s     = 1'b1;
        state_nx_s = win_valid_s ? ST_ADDR : ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // address/data/write-enable mux for the winning client
  always_comb begin
    sel_a_s  = {AW{1'b0}};
    sel_d_s  = {DW{1'b0}};
    sel_we_s = 1'b0;
    case (win_owner_s)
      OWN_VGA: sel_a_s = AW'({VGA_BASE, vga_a});
      OWN_CPU: begin
        sel_a_s  = cpu_a;
        sel_d_s  = cpu_d;
        sel_we_s = cpu_we;
      end
      OWN_LDR: begin
        sel_a_s  = ldr_a;
        sel_d_s  = ldr_d;
        sel_we_s = ldr_we;
      end
      default: sel_we_s = 1'b0;
    endcase
  end

  // slot FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // datapath: RAM command latch, read-data capture and ack pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r   <= OWN_VGA;
      slot_we_r <= 1'b0;
      ram_a_r   <= {AW{1'b0}};
      ram_d_r   <= {DW{1'b0}};
      ram_we_r  <= 1'b0;
      cpu_q_r   <= {DW{1'b0}};
      vga_q_r   <= {DW{1'b0}};
      ldr_q_r   <= {DW{1'b0}};
      cpu_ack_r <= 1'b0;
      vga_ack_r <= 1'b0;
      ldr_ack_r <= 1'b0;
    end else begin
      cpu_ack_r <= done_s & (owner_r == OWN_CPU);
      vga_ack_r <= done_s & (owner_r == OWN_VGA);
      ldr_ack_r <= done_s & (owner_r == OWN_LDR);
      if (done_s && !slot_we_r) begin
        case (owner_r)
          OWN_VGA: vga_q_r <= ram_q;
          OWN_CPU: cpu_q_r <= ram_q;
          OWN_LDR: ldr_q_r <= ram_q;
          default: vga_q_r <= vga_q_r;
        endcase
      end
      if (arb_s && win_valid_s) begin
        owner_r   <= win_owner_s;
        ram_a_r   <= sel_a_s;
        ram_d_r   <= sel_d_s;
        ram_we_r  <= sel_we_s;
        slot_we_r <= sel_we_s;
      end else begin
        ram_we_r  <= 1'b0;
      end
    end
  end

  // loader starvation counter, saturating
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!ldr_req || (arb_s && ldr_win_s)) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (arb_s && ldr_pend_s && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign ram_a   = ram_a_r;
  assign ram_d   = ram_d_r;
  assign ram_we  = ram_we_r;
  assign cpu_q   = cpu_q_r;
  assign vga_q   = vga_q_r;
  assign ldr_q   = ldr_q_r;
  assign cpu_ack = cpu_ack_r;
  assign cpu_ce  = cpu_ack_r;
  assign vga_ack = vga_ack_r;
  assign ldr_ack = ldr_ack_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural synchronous RAM, a table of
// CPU/loader transactions, and hand-written reset, priority and starvation sequences.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock, reset;
  logic        cpu_req, cpu_we, cpu_ack, cpu_ce;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d, cpu_q;
  logic        vga_req, vga_ack;
  logic [12:0] vga_a;
  logic [7:0]  vga_q;
  logic        ldr_req, ldr_we, ldr_ack;
  logic [15:0] ldr_a;
  logic [7:0]  ldr_d, ldr_q;
  logic [15:0] ram_a;
  logic [7:0]  ram_d, ram_q;
  logic        ram_we;

  logic [7:0]  mem [0:65535];
  int          total, bad;

  typedef struct {
    logic        is_ldr;
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_q;
  } vec_t;
  vec_t vecs [10];

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_we(cpu_we),
    .cpu_q(cpu_q), .cpu_ack(cpu_ack), .cpu_ce(cpu_ce),
    .vga_req(vga_req), .vga_a(vga_a), .vga_q(vga_q), .vga_ack(vga_ack),
    .ldr_req(ldr_req), .ldr_a(ldr_a), .ldr_d(ldr_d), .ldr_we(ldr_we),
    .ldr_q(ldr_q), .ldr_ack(ldr_ack),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // single-port synchronous RAM: read data valid the cycle after the address
  always @(posedge clock) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ack_of(input int w);
    return (w == 0) ? vga_ack : (w == 1) ? cpu_ack : ldr_ack;
  endfunction

  // returns number of edges until the selected ack is seen, 0 on timeout
  task automatic wait_ack(input int w, output int n);
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (ack_of(w)) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n, we_cnt, ncpu, nvga;
    logic got;
    logic [15:0] a_seen;
    logic [7:0]  q_seen;
    logic [3:0]  cnt_seen;
    logic        ce_seen, ack_after;

    total = 0; bad = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h11; mem[16'h1234] = 8'h5A; mem[16'h0300] = 8'h42;
    mem[16'h0400] = 8'h24; mem[16'h4000] = 8'h3C; mem[16'h4010] = 8'hE1;
    mem[16'h0500] = 8'h6B; mem[16'h3000] = 8'h99;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A};
    vecs[1] = '{1'b0, 1'b1, 16'h0100, 8'h77, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h77};
    vecs[3] = '{1'b1, 1'b1, 16'h2000, 8'hC3, 8'h24};
    vecs[4] = '{1'b1, 1'b0, 16'h2000, 8'h00, 8'hC3};
    vecs[5] = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'hC3};
    vecs[6] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'h5A};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 8'hA5, 8'hC3};
    vecs[8] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hA5};
    vecs[9] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h11};

    // reset held 3 cycles with every client requesting
    reset = 1'b1;
    cpu_req = 1'b1; cpu_a = 16'h0300; cpu_d = 8'h00; cpu_we = 1'b0;
    vga_req = 1'b1; vga_a = 13'h0000;
    ldr_req = 1'b1; ldr_a = 16'h0400; ldr_d = 8'h00; ldr_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_quiet", {27'd0, vga_ack, cpu_ack, ldr_ack, ram_we, cpu_ce}, 32'd0);
    end
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_q", {8'd0, cpu_q, vga_q, ldr_q}, 32'd0);
    reset = 1'b0;
    wait_ack(0, n);
    check("rst_vga_lat", n, 3);
    check("rst_vga_q", 32'(vga_q), 32'h3C);
    vga_req = 1'b0;
    wait_ack(1, n);
    check("rst_cpu_lat", n, 2);
    check("rst_cpu_q", 32'(cpu_q), 32'h42);
    cpu_req = 1'b0;
    wait_ack(2, n);
    check("rst_ldr_lat", n, 2);
    check("rst_ldr_q", 32'(ldr_q), 32'h24);
    ldr_req = 1'b0;
    tick(); tick();

    // table of single CPU/loader transactions from an idle arbiter
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_ldr) begin
        ldr_a = vecs[i].a; ldr_d = vecs[i].d; ldr_we = vecs[i].we; ldr_req = 1'b1;
      end else begin
        cpu_a = vecs[i].a; cpu_d = vecs[i].d; cpu_we = vecs[i].we; cpu_req = 1'b1;
      end
      n = 0; we_cnt = 0; a_seen = 16'h0; q_seen = 8'h0; ce_seen = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (c == 1) a_seen = ram_a;
        we_cnt += int'(ram_we);
        if (ack_of(vecs[i].is_ldr ? 2 : 1)) begin
          n = c;
          q_seen = vecs[i].is_ldr ? ldr_q : cpu_q;
          ce_seen = cpu_ce;
          break;
        end
      end
      cpu_req = 1'b0; ldr_req = 1'b0;
      check($sformatf("vec%0d_lat", i), n, 3);
      check($sformatf("vec%0d_ram_a", i), 32'(a_seen), 32'(vecs[i].a));
      check($sformatf("vec%0d_q", i), 32'(q_seen), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_we_cnt", i), we_cnt, int'(vecs[i].we));
      check($sformatf("vec%0d_ce", i), 32'(ce_seen), 32'(!vecs[i].is_ldr));
      tick();
      ack_after = ack_of(vecs[i].is_ldr ? 2 : 1);
      check($sformatf("vec%0d_ack_1cyc", i), {31'd0, ack_after} | 32'(ram_we), 32'd0);
      tick();
    end

    // VGA and CPU in the same cycle: VGA slot first, CPU slot right behind
    vga_a = 13'h0010; cpu_a = 16'h0500; cpu_we = 1'b0;
    vga_req = 1'b1; cpu_req = 1'b1;
    tick();
    check("prio_ram_a_vga", 32'(ram_a), 32'h4010);
    check("prio_we_vga", 32'(ram_we), 32'd0);
    wait_ack(0, n);
    vga_req = 1'b0;
    check("prio_vga_lat", n, 2);
    check("prio_vga_q", 32'(vga_q), 32'hE1);
    check("prio_ram_a_cpu", 32'(ram_a), 32'h0500);
    wait_ack(1, n);
    cpu_req = 1'b0;
    check("prio_cpu_lat", n, 2);
    check("prio_cpu_q", 32'(cpu_q), 32'h6B);
    tick(); tick();

    // CPU and VGA requesting back to back keep the loader out until starvation relief
    cpu_a = 16'h1234; ldr_a = 16'h3000; ldr_we = 1'b0;
    cpu_req = 1'b1; ldr_req = 1'b1;
    tick();
    vga_req = 1'b1;
    ncpu = 0; nvga = 0; got = 1'b0; cnt_seen = 4'hF; q_seen = 8'h00;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (cpu_ack) ncpu++;
      if (vga_ack) nvga++;
      if (ldr_ack) begin
        got = 1'b1;
        cnt_seen = dut.starve_cnt_r;
        q_seen = ldr_q;
        break;
      end
    end
    cpu_req = 1'b0; vga_req = 1'b0; ldr_req = 1'b0;
    check("starve_ldr_ack", 32'(got), 32'd1);
    check("starve_cpu_slots", ncpu, 4);
    check("starve_vga_slots", nvga, 4);
    check("starve_cnt_clr", 32'(cnt_seen), 32'd0);
    check("starve_ldr_q", 32'(q_seen), 32'h99);
    for (int i = 0; i < 8; i++) tick();

    // reset during DATA of a CPU read drops the slot; request is then served normally
    cpu_a = 16'h0100; cpu_we = 1'b0; cpu_req = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstdata_no_ack", 32'(cpu_ack), 32'd0);
    check("rstdata_idle", 32'(dut.state_r), 32'(ST_IDLE));
    check("rstdata_q_clr", 32'(cpu_q), 32'd0);
    reset = 1'b0;
    wait_ack(1, n);
    cpu_req = 1'b0;
    check("rstdata_lat", n, 3);
    check("rstdata_q", 32'(cpu_q), 32'h77);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
